// File: rtl/ceespu_sprite_fetcher.sv
// ceespu_sprite_fetcher: per-line bitmap fetcher and pixel generator
// for one hardware sprite.
module ceespu_sprite_fetcher #(
    parameter int SPRITE_WIDTH  = 24,
    parameter int SPRITE_HEIGHT = 21,
    parameter int ADDR_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [10:0]           x,
    input  logic [9:0]            y,
    input  logic                  new_x,
    input  logic                  new_y,
    input  logic                  sys_we,
    input  logic [1:0]            sys_addr,
    input  logic [15:0]           sys_data,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [7:0]            mem_data,
    output logic                  active,
    output logic                  pixel_on
);

    typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

    state_t state;

    logic [10:0]             sh_x;
    logic [9:0]              sh_y;
    logic [ADDR_WIDTH-1:0]   sh_base;
    logic                    sh_en;

    logic [10:0]             cur_x;
    logic [SPRITE_WIDTH-1:0] stage;
    logic                    stage_valid;
    logic [SPRITE_WIDTH-1:0] disp_row;
    logic                    line_valid;
    logic [1:0]              byte_idx;

    logic [9:0]              next_row;
    logic [11:0]             row_off;
    logic                    start;
    logic [10:0]             dx;
    logic                    in_box;
    logic [SPRITE_WIDTH-1:0] shifted;

    // Row of the sprite needed on the next line, and its byte offset.
    always_comb begin
        next_row = y + 10'd1 - sh_y;
        row_off  = {2'b00, next_row} * 12'd3;
        start    = sh_en && (next_row < 10'(SPRITE_HEIGHT));
        dx       = x - cur_x;
        in_box   = line_valid && (dx < 11'(SPRITE_WIDTH));
        shifted  = disp_row << dx[4:0];
    end

    // CPU-visible shadow registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_x    <= '0;
            sh_y    <= '0;
            sh_base <= '0;
            sh_en   <= 1'b0;
        end else if (sys_we) begin
            unique case (sys_addr)
                2'd0: sh_x    <= sys_data[10:0];
                2'd1: sh_y    <= sys_data[9:0];
                2'd2: sh_base <= ADDR_WIDTH'(sys_data);
                2'd3: sh_en   <= sys_data[0];
            endcase
        end
    end

    // Line swap and three-byte fetch of the next row.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            byte_idx    <= 2'd0;
            stage       <= '0;
            stage_valid <= 1'b0;
            disp_row    <= '0;
            line_valid  <= 1'b0;
            cur_x       <= '0;
        end else if (new_y) begin
            disp_row    <= stage;
            line_valid  <= stage_valid;
            stage_valid <= 1'b0;
            cur_x       <= sh_x;
            byte_idx    <= 2'd0;
            if (start) begin
                state    <= FETCH;
                mem_addr <= sh_base + ADDR_WIDTH'(row_off);
                // An aborted fetch leaves the request low for one cycle.
                mem_req  <= (state != FETCH);
            end else begin
                state   <= IDLE;
                mem_req <= 1'b0;
            end
        end else begin
            unique case (state)
                FETCH: begin
                    if (!mem_req) begin
                        mem_req <= 1'b1;
                    end else if (mem_ack) begin
                        unique case (byte_idx)
                            2'd0:    stage[23:16] <= mem_data;
                            2'd1:    stage[15:8]  <= mem_data;
                            default: stage[7:0]   <= mem_data;
                        endcase
                        if (byte_idx == 2'd2) begin
                            mem_req     <= 1'b0;
                            stage_valid <= 1'b1;
                            state       <= DONE;
                        end else begin
                            byte_idx <= byte_idx + 2'd1;
                            mem_addr <= mem_addr + ADDR_WIDTH'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Per-pixel box test and bitmap bit select.
    always_ff @(posedge clk) begin
        if (rst) begin
            active   <= 1'b0;
            pixel_on <= 1'b0;
        end else if (new_x) begin
            active   <= in_box;
            pixel_on <= in_box && shifted[SPRITE_WIDTH-1];
        end
    end

endmodule

// File: tb/tb_ceespu_sprite_fetcher.sv
// Testbench for ceespu_sprite_fetcher: behavioural line/pixel model,
// zero/multi-wait memory responder and directed scenarios.
module tb_ceespu_sprite_fetcher;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] x;
    logic [9:0]  y;
    logic        new_x, new_y, sys_we;
    logic [1:0]  sys_addr;
    logic [15:0] sys_data;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_data = 8'h00;
    logic        active, pixel_on;

    always #5 clk = ~clk;

    ceespu_sprite_fetcher dut (
        .clk(clk), .rst(rst), .x(x), .y(y),
        .new_x(new_x), .new_y(new_y),
        .sys_we(sys_we), .sys_addr(sys_addr), .sys_data(sys_data),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_data(mem_data),
        .active(active), .pixel_on(pixel_on)
    );

    int tests = 0;
    int fails = 0;

    logic [7:0] mem [0:65535];
    int wait_cfg   = 0;
    int ack_budget = 1000000;
    int wcnt       = 0;

    // model state
    logic [10:0] s_sx;
    logic [9:0]  s_sy;
    logic [15:0] s_base;
    logic        s_en;
    logic [10:0] m_wsx;
    logic        m_lv;
    logic [23:0] m_bits, m_next;
    logic        m_fetching, m_done;
    int          m_acks;
    logic [15:0] addr_q [$];
    logic        exp_active, exp_pix;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory responder: acks after wait_cfg idle cycles of an open request.
    always @(negedge clk) begin
        if (!rst && mem_req && ack_budget > 0 && wcnt >= wait_cfg) begin
            mem_ack  = 1'b1;
            mem_data = mem[mem_addr];
            ack_budget--;
            wcnt = 0;
        end else begin
            mem_ack = 1'b0;
            if (mem_req) wcnt++;
            else wcnt = 0;
        end
    end

    // Behavioural model: what each line and pixel must show.
    always @(posedge clk) begin
        logic [10:0] dx;
        logic [9:0]  row;
        logic [15:0] a;
        if (rst) begin
            s_sx = 0; s_sy = 0; s_base = 0; s_en = 0;
            m_wsx = 0; m_lv = 0; m_bits = 0; m_next = 0;
            m_fetching = 0; m_done = 0; m_acks = 0;
            addr_q.delete();
            exp_active = 0; exp_pix = 0;
        end else begin
            if (new_x) begin
                dx = x - m_wsx;
                exp_active = m_lv && (dx < 11'd24);
                exp_pix = 1'b0;
                if (exp_active) exp_pix = m_bits[5'(23 - int'(dx))];
            end
            if (mem_ack && !new_y && m_fetching) begin
                check("ack_addr", mem_addr, addr_q.pop_front());
                m_acks++;
                if (m_acks == 3) begin
                    m_fetching = 0;
                    m_done = 1;
                end
            end
            if (new_y) begin
                row = y + 10'd1 - s_sy;
                m_lv = m_done;
                m_bits = m_next;
                m_done = 0;
                m_wsx = s_sx;
                addr_q.delete();
                m_fetching = 0;
                if (s_en && row < 10'd21) begin
                    a = s_base + 16'(int'(row) * 3);
                    for (int i = 0; i < 3; i++) addr_q.push_back(16'(a + 16'(i)));
                    m_next = {mem[a], mem[16'(a + 16'd1)], mem[16'(a + 16'd2)]};
                    m_fetching = 1;
                    m_acks = 0;
                end
            end
            if (sys_we) begin
                case (sys_addr)
                    2'd0: s_sx = sys_data[10:0];
                    2'd1: s_sy = sys_data[9:0];
                    2'd2: s_base = sys_data;
                    default: s_en = sys_data[0];
                endcase
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (!rst) begin
            check("active", active, exp_active);
            check("pixel_on", pixel_on, exp_pix);
            if (mem_req) begin
                check("req_expected", 1'b1, m_fetching);
                if (m_fetching && addr_q.size() > 0)
                    check("addr_stable", mem_addr, addr_q[0]);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        sys_we = 1'b1; sys_addr = a; sys_data = d;
        tick();
        sys_we = 1'b0;
    endtask

    task automatic line(input logic [9:0] yv);
        new_y = 1'b1; y = yv;
        tick();
        new_y = 1'b0;
    endtask

    task automatic pix(input logic [10:0] xv);
        new_x = 1'b1; x = xv;
        tick();
        new_x = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (m_fetching && n < 300) begin
            tick();
            n++;
        end
        check("fetch_timeout", m_fetching, 1'b0);
    endtask

    initial begin
        logic [23:0] pat;
        logic        ea, ep;
        for (int i = 0; i < 65536; i++) mem[i] = 8'(i * 7 + 3);
        mem[16'h1000] = 8'hA5; mem[16'h1001] = 8'hF0; mem[16'h1002] = 8'h0F;
        mem[16'h103C] = 8'h81; mem[16'h103D] = 8'h42; mem[16'h103E] = 8'h3C;
        mem[16'h200C] = 8'hC3; mem[16'h200D] = 8'h00; mem[16'h200E] = 8'h01;

        // reset with random inputs
        rst = 1'b1;
        repeat (2) begin
            x = 11'($urandom); y = 10'($urandom);
            new_x = 1'($urandom); new_y = 1'($urandom);
            sys_we = 1'($urandom); sys_addr = 2'($urandom);
            sys_data = 16'($urandom);
            tick();
        end
        rst = 1'b0;
        x = 0; y = 0; new_x = 0; new_y = 0;
        sys_we = 0; sys_addr = 0; sys_data = 0;
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_active", active, 1'b0);
        check("rst_pixel_on", pixel_on, 1'b0);
        line(10'd50);
        repeat (3) begin
            check("disabled_no_req", mem_req, 1'b0);
            tick();
        end

        // basic fetch and display
        wr(2'd0, 16'd200);
        wr(2'd1, 16'd100);
        wr(2'd2, 16'h1000);
        wr(2'd3, 16'd1);
        line(10'd99);
        check("basic_req", mem_req, 1'b1);
        check("basic_addr0", mem_addr, 16'h1000);
        wait_idle();
        line(10'd100);
        pat = 24'hA5F00F;
        for (int xv = 199; xv <= 224; xv++) begin
            pix(11'(xv));
            ea = (xv >= 200 && xv <= 223);
            ep = ea ? pat[5'(223 - xv)] : 1'b0;
            check("basic_active", active, ea);
            check("basic_pixel", pixel_on, ep);
        end
        wait_idle();

        // bottom edge
        line(10'd119);
        check("bottom_addr", mem_addr, 16'h103C);
        wait_idle();
        line(10'd120);
        check("bottom_no_req", mem_req, 1'b0);
        repeat (3) begin
            tick();
            check("bottom_no_req", mem_req, 1'b0);
        end
        pix(11'd200);
        check("row20_active", active, 1'b1);
        check("row20_px200", pixel_on, 1'b1);
        pix(11'd201);
        check("row20_px201", pixel_on, 1'b0);
        pix(11'd207);
        check("row20_px207", pixel_on, 1'b1);
        line(10'd121);
        pix(11'd200);
        check("after_bottom_blank", active, 1'b0);

        // abort: third ack withheld past the next line start
        ack_budget = 2;
        line(10'd99);
        check("abort_addr0", mem_addr, 16'h1000);
        repeat (8) tick();
        check("abort_hold_req", mem_req, 1'b1);
        check("abort_hold_addr", mem_addr, 16'h1002);
        ack_budget = 1000000;
        line(10'd100);
        check("abort_gap", mem_req, 1'b0);
        tick();
        check("abort_restart", mem_req, 1'b1);
        check("abort_restart_addr", mem_addr, 16'h1003);
        pix(11'd200);
        check("abort_blank_200", active, 1'b0);
        pix(11'd210);
        check("abort_blank_210", active, 1'b0);
        wait_idle();
        line(10'd101);
        pix(11'd200);
        check("row1_active", active, 1'b1);
        check("row1_px200", pixel_on, 1'b0);
        pix(11'd203);
        check("row1_px203", pixel_on, 1'b1);
        wait_idle();

        // wrap of y+1 and row difference
        wr(2'd1, 16'd1020);
        wr(2'd2, 16'h2000);
        line(10'd1023);
        check("wrap_addr", mem_addr, 16'h200C);
        wait_idle();

        // wait states
        wait_cfg = 5;
        line(10'd1023);
        check("ws_addr0", mem_addr, 16'h200C);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("ws_addr_stable", mem_addr, 16'h200C);
        end
        wait_idle();
        wait_cfg = 0;

        // sprite_x write mid-line moves the window only next line
        line(10'd1023);
        pix(11'd200);
        check("regt_old_active", active, 1'b1);
        check("regt_old_px", pixel_on, 1'b1);
        wr(2'd0, 16'd300);
        pix(11'd300);
        check("regt_old_300", active, 1'b0);
        pix(11'd201);
        check("regt_old_px201", pixel_on, 1'b1);
        wait_idle();
        line(10'd1023);
        pix(11'd200);
        check("regt_new_200", active, 1'b0);
        pix(11'd300);
        check("regt_new_300", active, 1'b1);
        check("regt_new_px300", pixel_on, 1'b1);
        pix(11'd323);
        check("regt_new_px323", pixel_on, 1'b1);
        pix(11'd324);
        check("regt_new_324", active, 1'b0);
        wait_idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
